// File: rtl/gpio_irq_arbiter_if.sv
//------------------------------------------------------------------------------
// gpio_irq_arbiter_if : interrupt status/request bundle between GPIO and CPU side
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface gpio_irq_arbiter_if #(
  parameter int PIN_COUNT = 32,
  parameter int ID_WIDTH  = 5
);
  logic [PIN_COUNT-1:0] int_status;
  logic [PIN_COUNT-1:0] irq_mask;
  logic                 irq_ack;
  logic                 irq_req;
  logic [ID_WIDTH-1:0]  irq_id;
  logic [PIN_COUNT-1:0] int_clear;
  logic                 irq_pending;
  logic                 timeout_err;
  logic                 spurious;

  modport master (
    output int_status, irq_mask, irq_ack,
    input  irq_req, irq_id, int_clear, irq_pending, timeout_err, spurious
  );

  modport slave (
    input  int_status, irq_mask, irq_ack,
    output irq_req, irq_id, int_clear, irq_pending, timeout_err, spurious
  );
endinterface

`default_nettype wire

// File: rtl/gpio_irq_arbiter.sv
//------------------------------------------------------------------------------
// gpio_irq_arbiter : picks one unmasked pending GPIO interrupt, requests the CPU,
//                    and pulses the matching clear after acknowledge.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gpio_irq_arbiter #(
  parameter int PIN_COUNT   = 32,
  parameter int ID_WIDTH    = 5,
  parameter int RR_MODE     = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  gpio_irq_arbiter_if.slave     bus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e               state_q;
  logic                 req_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic [PIN_COUNT-1:0] clr_q;
  logic                 pend_q;
  logic                 tmo_q;
  logic                 spu_q;
  logic [ID_WIDTH-1:0]  ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [PIN_COUNT-1:0] cand;
  logic [PIN_COUNT-1:0] above_ptr;
  logic [PIN_COUNT-1:0] cand_hi;
  logic [ID_WIDTH-1:0]  win_id;
  logic [ID_WIDTH-1:0]  next_ptr;
  logic                 withdraw;
  logic                 timeout_hit;

  function automatic logic [ID_WIDTH-1:0] lowest(input logic [PIN_COUNT-1:0] v);
    lowest = '0;
    for (int i = PIN_COUNT - 1; i >= 0; i--) begin
      if (v[i]) lowest = ID_WIDTH'(i);
    end
  endfunction

  assign cand = bus.int_status & ~bus.irq_mask;

  generate
    for (genvar g = 0; g < PIN_COUNT; g++) begin : g_above_ptr
      assign above_ptr[g] = (ID_WIDTH'(g) >= ptr_q);
    end
  endgenerate

  // Round-robin: search from the pointer upward, fall back to the lowest index to wrap.
  assign cand_hi = cand & above_ptr;
  assign win_id  = ((RR_MODE != 0) && (|cand_hi)) ? lowest(cand_hi) : lowest(cand);

  assign next_ptr    = (id_q == ID_WIDTH'(PIN_COUNT - 1)) ? '0 : id_q + ID_WIDTH'(1);
  assign withdraw    = !bus.int_status[id_q] || bus.irq_mask[id_q];
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
      clr_q   <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
      spu_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pend_q <= |cand;
      clr_q  <= '0;
      tmo_q  <= 1'b0;
      spu_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|cand) begin
            id_q    <= win_id;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // Ack wins over withdraw, which wins over timeout.
          if (bus.irq_ack) begin
            req_q   <= 1'b0;
            clr_q   <= PIN_COUNT'(1) << id_q;
            state_q <= S_CLEAR;
            if (RR_MODE != 0) ptr_q <= next_ptr;
          end else if (withdraw) begin
            req_q   <= 1'b0;
            spu_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
            if (RR_MODE != 0) ptr_q <= next_ptr;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_CLEAR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.irq_req     = req_q;
  assign bus.irq_id      = id_q;
  assign bus.int_clear   = clr_q;
  assign bus.irq_pending = pend_q;
  assign bus.timeout_err = tmo_q;
  assign bus.spurious    = spu_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_irq_arbiter.sv
//------------------------------------------------------------------------------
// tb_gpio_irq_arbiter : directed and random checks of a fixed-priority and a
//                       round-robin arbiter instance against a reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_gpio_irq_arbiter;

  localparam int N  = 32;
  localparam int IW = 5;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] st_f = '0, st_r = '0, mk_f = '0, mk_r = '0;
  logic         ak_f = 1'b0, ak_r = 1'b0;

  int tests = 0;
  int fails = 0;

  gpio_irq_arbiter_if #(.PIN_COUNT(N), .ID_WIDTH(IW)) bf ();
  gpio_irq_arbiter_if #(.PIN_COUNT(N), .ID_WIDTH(IW)) br ();

  assign bf.int_status = st_f;
  assign bf.irq_mask   = mk_f;
  assign bf.irq_ack    = ak_f;
  assign br.int_status = st_r;
  assign br.irq_mask   = mk_r;
  assign br.irq_ack    = ak_r;

  gpio_irq_arbiter #(.PIN_COUNT(N), .ID_WIDTH(IW), .RR_MODE(0), .ACK_TIMEOUT(TO)) dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bf.slave)
  );

  gpio_irq_arbiter #(.PIN_COUNT(N), .ID_WIDTH(IW), .RR_MODE(1), .ACK_TIMEOUT(TO)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (br.slave)
  );

  // Reference model: phase 0 = waiting, 1 = requesting, 2 = clearing.
  typedef struct {
    int          phase;
    int          id;
    int          ptr;
    int          waited;
    bit          req;
    bit          pend;
    bit          tmo;
    bit          spu;
    logic [31:0] clr;
  } mdl_t;

  mdl_t mf = '{default: 0};
  mdl_t mr = '{default: 0};

  function automatic mdl_t step(mdl_t m, bit rn, logic [31:0] s, logic [31:0] mk, bit ak, bit rr);
    mdl_t n = m;
    logic [31:0] c = s & ~mk;
    int win = -1;
    n.clr = '0;
    n.tmo = 1'b0;
    n.spu = 1'b0;
    if (!rn) begin
      n.phase = 0; n.id = 0; n.ptr = 0; n.waited = 0; n.req = 1'b0; n.pend = 1'b0;
      return n;
    end
    n.pend = (c != 0);
    if (m.phase == 0) begin
      if (c != 0) begin
        for (int k = 0; k < N; k++) begin
          int idx = rr ? (m.ptr + k) % N : k;
          if (win < 0 && c[idx]) win = idx;
        end
        n.id = win; n.req = 1'b1; n.waited = 0; n.phase = 1;
      end
    end else if (m.phase == 1) begin
      if (ak) begin
        n.req = 1'b0; n.clr = 32'd1 << m.id; n.phase = 2;
        if (rr) n.ptr = (m.id + 1) % N;
      end else if (!s[m.id] || mk[m.id]) begin
        n.req = 1'b0; n.spu = 1'b1; n.phase = 0;
      end else if (TO != 0 && m.waited == TO - 1) begin
        n.req = 1'b0; n.tmo = 1'b1; n.phase = 0;
        if (rr) n.ptr = (m.id + 1) % N;
      end else begin
        n.waited = m.waited + 1;
      end
    end else begin
      n.phase = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mf <= step(mf, rst_n, st_f, mk_f, ak_f, 1'b0);
    mr <= step(mr, rst_n, st_r, mk_r, ak_r, 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("f.req",  32'(bf.irq_req),     32'(mf.req));
    chk("f.id",   32'(bf.irq_id),      32'(mf.id));
    chk("f.clr",  bf.int_clear,        mf.clr);
    chk("f.pend", 32'(bf.irq_pending), 32'(mf.pend));
    chk("f.tmo",  32'(bf.timeout_err), 32'(mf.tmo));
    chk("f.spu",  32'(bf.spurious),    32'(mf.spu));
    chk("r.req",  32'(br.irq_req),     32'(mr.req));
    chk("r.id",   32'(br.irq_id),      32'(mr.id));
    chk("r.clr",  br.int_clear,        mr.clr);
    chk("r.pend", 32'(br.irq_pending), 32'(mr.pend));
    chk("r.tmo",  32'(br.timeout_err), 32'(mr.tmo));
    chk("r.spu",  32'(br.spurious),    32'(mr.spu));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_req_r();
    int n = 0;
    while (!br.irq_req && n < 10) begin
      tick();
      n++;
    end
    chk("wait_req_r", 32'(br.irq_req), 32'd1);
  endtask

  task automatic wait_req_f();
    int n = 0;
    while (!bf.irq_req && n < 10) begin
      tick();
      n++;
    end
    chk("wait_req_f", 32'(bf.irq_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [5] = '{0, 1, 31, 0, 1};
    int hi;
    int n;

    // Reset with every source pending
    st_f = '1; st_r = '1;
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst.req_f",  32'(bf.irq_req), 32'd0);
    chk("rst.clr_f",  bf.int_clear, 32'd0);
    chk("rst.pend_r", 32'(br.irq_pending), 32'd0);
    chk("rst.id_r",   32'(br.irq_id), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel.req_f", 32'(bf.irq_req), 32'd1);
    chk("rel.id_f",  32'(bf.irq_id), 32'd0);
    chk("rel.req_r", 32'(br.irq_req), 32'd1);
    chk("rel.id_r",  32'(br.irq_id), 32'd0);

    // Fixed priority
    st_f = 32'h0000_0120; st_r = '0;
    do_reset();
    tick();
    chk("fp.id5", 32'(bf.irq_id), 32'd5);
    ak_f = 1'b1;
    tick();
    ak_f = 1'b0;
    chk("fp.clr", bf.int_clear, 32'h0000_0020);
    chk("fp.req_drop", 32'(bf.irq_req), 32'd0);
    st_f = 32'h0000_0100;
    tick();
    chk("fp.clr_1cyc", bf.int_clear, 32'd0);
    tick();
    chk("fp.req8", 32'(bf.irq_req), 32'd1);
    chk("fp.id8",  32'(bf.irq_id), 32'd8);

    // Round-robin with a constant level
    st_f = '0; st_r = 32'h8000_0003;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_req_r();
      chk("rr.id", 32'(br.irq_id), 32'(seq[i]));
      ak_r = 1'b1;
      tick();
      ak_r = 1'b0;
      chk("rr.clr", br.int_clear, 32'd1 << seq[i]);
    end

    // Withdraw before ack
    st_r = 32'd1 << 7;
    do_reset();
    tick();
    chk("wd.id7", 32'(br.irq_id), 32'd7);
    st_r = '0;
    tick();
    chk("wd.spu", 32'(br.spurious), 32'd1);
    chk("wd.req", 32'(br.irq_req), 32'd0);
    chk("wd.clr", br.int_clear, 32'd0);
    tick();
    chk("wd.spu_1cyc", 32'(br.spurious), 32'd0);

    // Timeout, then round-robin moves past the timed-out source
    st_r = 32'h0000_000C;
    do_reset();
    tick();
    chk("to.id2", 32'(br.irq_id), 32'd2);
    hi = 0; n = 0;
    while (!br.timeout_err && n < 20) begin
      if (br.irq_req) hi++;
      tick();
      n++;
    end
    chk("to.seen", 32'(br.timeout_err), 32'd1);
    chk("to.len", 32'(hi), 32'd4);
    tick();
    chk("to.tmo_1cyc", 32'(br.timeout_err), 32'd0);
    chk("to.id3", 32'(br.irq_id), 32'd3);
    chk("to.req3", 32'(br.irq_req), 32'd1);

    // Ack coinciding with status withdrawal: ack wins
    st_r = '0; st_f = 32'd1 << 4;
    do_reset();
    tick();
    ak_f = 1'b1; st_f = '0;
    tick();
    ak_f = 1'b0;
    chk("sim.clr", bf.int_clear, 32'h0000_0010);
    chk("sim.spu", 32'(bf.spurious), 32'd0);

    // Reset during a request abandons it with no clear
    st_f = 32'd1 << 4;
    wait_req_f();
    ak_f = 1'b1; rst_n = 1'b0;
    tick();
    ak_f = 1'b0; rst_n = 1'b1;
    chk("rq_rst.req", 32'(bf.irq_req), 32'd0);
    chk("rq_rst.clr", bf.int_clear, 32'd0);
    chk("rq_rst.id",  32'(bf.irq_id), 32'd0);
    chk("rq_rst.pend", 32'(bf.irq_pending), 32'd0);

    // Random traffic against the model
    st_f = '0; st_r = '0;
    for (int c = 0; c < 3000; c++) begin
      st_f = (st_f & ~mf.clr) ^ ($urandom & $urandom & $urandom);
      st_r = (st_r & ~mr.clr) ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mk_f = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 15) == 0) mk_r = $urandom & $urandom & $urandom;
      ak_f  = ($urandom_range(0, 3) == 0);
      ak_r  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
